// File: rtl/keypad_scan_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | keypad_scan_driver                                                          |
// | 4x3 matrix keypad scanner with frame debounce and one-pulse-per-press output.|
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module keypad_scan_driver #(
  parameter int SCAN_DIV        = 5000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] col_in,
  output logic [3:0] row_out,
  output logic       key_valid,
  output logic [3:0] key_value,
  output logic       key_held
);

  localparam int c_DIV_W = $clog2(SCAN_DIV);
  localparam int c_STB_W = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [c_DIV_W-1:0] c_DWELL_LAST = c_DIV_W'(SCAN_DIV - 1);
  localparam logic [c_STB_W-1:0] c_STABLE     = c_STB_W'(DEBOUNCE_FRAMES);
  localparam logic [1:0] c_NONE   = 2'd0;
  localparam logic [1:0] c_SINGLE = 2'd1;
  localparam logic [1:0] c_MULTI  = 2'd2;

  typedef enum logic [0:0] {RELEASED = 1'b0, PRESSED = 1'b1} state_t;

  state_t              r_state;
  logic [2:0]          r_sync1, r_sync2;
  logic [c_DIV_W-1:0]  r_dwell;
  logic [1:0]          r_row;
  logic [3:0]          r_row_out;
  logic [1:0]          r_acc_cnt;
  logic [3:0]          r_acc_code;
  logic [1:0]          r_prev_kind;
  logic [3:0]          r_prev_code;
  logic [c_STB_W-1:0]  r_stable;
  logic                r_key_valid;
  logic [3:0]          r_key_value;
  logic                r_key_held;

  logic [2:0]          w_hits;
  logic [1:0]          w_row_cnt;
  logic [3:0]          w_row_code;
  logic [2:0]          w_sum;
  logic [1:0]          w_kind;
  logic [3:0]          w_code;
  logic                w_same;
  logic [c_STB_W-1:0]  w_next_stable;
  logic                w_is_stable;
  logic                w_sample;
  logic                w_frame_end;
  logic [1:0]          w_row_next;

  function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
    if (row == 2'd3) begin
      case (col)
        2'd0:    return 4'd10;
        2'd1:    return 4'd0;
        default: return 4'd11;
      endcase
    end
    return 4'(row) * 4'd3 + 4'(col) + 4'd1;
  endfunction

  always_comb begin
    w_hits     = ~r_sync2;
    w_row_cnt  = 2'(w_hits[0]) + 2'(w_hits[1]) + 2'(w_hits[2]);
    w_row_code = 4'd0;
    if (w_hits[0])      w_row_code = key_code(r_row, 2'd0);
    else if (w_hits[1]) w_row_code = key_code(r_row, 2'd1);
    else if (w_hits[2]) w_row_code = key_code(r_row, 2'd2);

    // Frame tally including the row being sampled now; count saturates at 2 (= MULTI).
    w_sum  = {1'b0, r_acc_cnt} + {1'b0, w_row_cnt};
    w_kind = (w_sum == 3'd0) ? c_NONE : ((w_sum == 3'd1) ? c_SINGLE : c_MULTI);
    w_code = (w_kind != c_SINGLE) ? 4'd0 : ((w_row_cnt != 2'd0) ? w_row_code : r_acc_code);

    w_same        = (w_kind == r_prev_kind) && (w_code == r_prev_code);
    w_next_stable = !w_same ? c_STB_W'(1)
                  : ((r_stable == c_STABLE) ? r_stable : r_stable + c_STB_W'(1));
    w_is_stable   = (w_next_stable == c_STABLE);

    w_sample    = (r_dwell == c_DWELL_LAST);
    w_frame_end = w_sample && (r_row == 2'd3);
    w_row_next  = r_row + 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RELEASED;
      r_sync1     <= 3'b111;
      r_sync2     <= 3'b111;
      r_dwell     <= '0;
      r_row       <= 2'd0;
      r_row_out   <= 4'b1110;
      r_acc_cnt   <= 2'd0;
      r_acc_code  <= 4'd0;
      r_prev_kind <= c_NONE;
      r_prev_code <= 4'd0;
      r_stable    <= '0;
      r_key_valid <= 1'b0;
      r_key_value <= 4'd0;
      r_key_held  <= 1'b0;
    end else begin
      r_sync1     <= col_in;
      r_sync2     <= r_sync1;
      r_key_valid <= 1'b0;

      if (w_sample) begin
        r_dwell   <= '0;
        r_row     <= w_row_next;
        r_row_out <= ~(4'b0001 << w_row_next);
      end else begin
        r_dwell   <= r_dwell + c_DIV_W'(1);
      end

      if (w_frame_end) begin
        r_acc_cnt   <= 2'd0;
        r_acc_code  <= 4'd0;
        r_prev_kind <= w_kind;
        r_prev_code <= w_code;
        r_stable    <= w_next_stable;
        case (r_state)
          RELEASED: begin
            if (w_is_stable && w_kind == c_SINGLE) begin
              r_state     <= PRESSED;
              r_key_valid <= 1'b1;
              r_key_value <= w_code;
              r_key_held  <= 1'b1;
            end
          end
          PRESSED: begin
            if (w_is_stable && w_kind == c_NONE) begin
              r_state    <= RELEASED;
              r_key_held <= 1'b0;
            end
          end
          default: r_state <= RELEASED;
        endcase
      end else if (w_sample) begin
        r_acc_cnt  <= (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];
        r_acc_code <= (w_row_cnt != 2'd0) ? w_row_code : r_acc_code;
      end
    end
  end

  assign row_out   = r_row_out;
  assign key_valid = r_key_valid;
  assign key_value = r_key_value;
  assign key_held  = r_key_held;

endmodule
`default_nettype wire
